// File: rtl/fpu_operand_loader.sv
// Operand loader for the 10-bit FPU: gathers A, B and opcode from the pad bus over
// three write strobes, then fires a one-cycle start and waits for calc_done.
module fpu_operand_loader #(
    parameter int WIDTH       = 10,
    parameter int OP_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [11:0]      in,
    input  logic             calc_done,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic [OP_W-1:0]  op,
    output logic             start,
    output logic             busy,
    output logic             err
);

    localparam int LAST = SYNC_STAGES - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GOT_A     = 3'd1,
        GOT_B     = 3'd2,
        FIRE      = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    logic [11:0]      sync_r [SYNC_STAGES];
    logic             strobe_prev_r;
    logic             event_r;
    logic             clear_r;
    logic [WIDTH-1:0] payload_r;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] num1_r, num1_s;
    logic [WIDTH-1:0] num2_r, num2_s;
    logic [OP_W-1:0]  op_r, op_s;
    logic             err_r, err_s;
    logic             start_r;
    logic             busy_r;

    // Pad synchronizer: the whole bus moves together so payload stays aligned with strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 12'h000;
            end
        end else begin
            sync_r[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Rising-edge detect on the synced strobe, registered together with its payload
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_prev_r <= 1'b0;
            event_r       <= 1'b0;
            clear_r       <= 1'b0;
            payload_r     <= '0;
        end else begin
            strobe_prev_r <= sync_r[LAST][11];
            event_r       <= sync_r[LAST][11] & ~strobe_prev_r;
            clear_r       <= sync_r[LAST][10];
            payload_r     <= sync_r[LAST][WIDTH-1:0];
        end
    end

    // Next-state and capture decode for the load sequence
    always_comb begin
        state_s = state_r;
        num1_s  = num1_r;
        num2_s  = num2_r;
        op_s    = op_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (event_r && clear_r) begin
                    err_s = 1'b0;
                end else if (event_r) begin
                    num1_s  = payload_r;
                    state_s = GOT_A;
                end else begin
                    state_s = IDLE;
                end
            end
            GOT_A: begin
                if (event_r && clear_r) begin
                    err_s   = 1'b0;
                    state_s = IDLE;
                end else if (event_r) begin
                    num2_s  = payload_r;
                    state_s = GOT_B;
                end else begin
                    state_s = GOT_A;
                end
            end
            GOT_B: begin
                if (event_r && clear_r) begin
                    err_s   = 1'b0;
                    state_s = IDLE;
                end else if (event_r) begin
                    op_s    = payload_r[OP_W-1:0];
                    state_s = FIRE;
                end else begin
                    state_s = GOT_B;
                end
            end
            FIRE: begin
                // calc_done here is too early to be meaningful and is dropped
                state_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (event_r) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (calc_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, operand and flag registers; start/busy are decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            num1_r  <= '0;
            num2_r  <= '0;
            op_r    <= '0;
            err_r   <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            num1_r  <= num1_s;
            num2_r  <= num2_s;
            op_r    <= op_s;
            err_r   <= err_s;
            start_r <= (state_s == FIRE);
            busy_r  <= (state_s == WAIT_DONE);
        end
    end

    assign num1  = num1_r;
    assign num2  = num2_r;
    assign op    = op_r;
    assign start = start_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Scoreboard bench for fpu_operand_loader: a word-level reference model predicts each
// start transaction and the visible registers; a monitor checks every start pulse.
module tb_fpu_operand_loader;

    localparam int WIDTH = 10;
    localparam int OP_W  = 4;
    localparam int SS    = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [11:0]      in;
    logic             calc_done;
    logic [WIDTH-1:0] num1, num2;
    logic [OP_W-1:0]  op;
    logic             start, busy, err;

    always #5 clock = ~clock;

    fpu_operand_loader #(.WIDTH(WIDTH), .OP_W(OP_W), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset(reset), .in(in), .calc_done(calc_done),
        .num1(num1), .num2(num2), .op(op), .start(start), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  o;
        logic             e;
    } exp_t;

    exp_t             sb_q[$];
    int               chk_cnt  = 0;
    int               pass_cnt = 0;

    // reference model: words collected so far, last captured values, waiting flag
    logic [WIDTH-1:0] m_pend[$];
    logic [WIDTH-1:0] m_a, m_b;
    logic [OP_W-1:0]  m_op;
    logic             m_err, m_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        m_pend.delete();
        m_a = '0; m_b = '0; m_op = '0; m_err = 1'b0; m_wait = 1'b0;
    endfunction

    function automatic void model_event(input logic [WIDTH-1:0] p, input logic clr);
        exp_t x;
        if (m_wait) begin
            m_err = 1'b1;
        end else if (clr) begin
            m_pend.delete();
            m_err = 1'b0;
        end else begin
            m_pend.push_back(p);
            if (m_pend.size() == 1) m_a = p;
            else if (m_pend.size() == 2) m_b = p;
            else begin
                m_op = p[OP_W-1:0];
                x.a = m_a; x.b = m_b; x.o = m_op; x.e = m_err;
                sb_q.push_back(x);
                m_pend.delete();
                m_wait = 1'b1;
            end
        end
    endfunction

    // one host write; optionally raise calc_done in the cycle the loader is firing
    task automatic send_word(input logic [WIDTH-1:0] p, input logic clr, input bit done_in_fire);
        model_event(p, clr);
        in = {1'b1, clr, p};
        repeat (SS + 2) @(posedge clock);
        #2;
        if (done_in_fire) calc_done = 1'b1;
        in[11] = 1'b0;
        @(posedge clock);
        #2;
        calc_done = 1'b0;
        repeat (SS + 1) @(posedge clock);
        #2;
    endtask

    task automatic pulse_done();
        m_wait = 1'b0;
        calc_done = 1'b1;
        @(posedge clock);
        #2;
        calc_done = 1'b0;
        @(posedge clock);
        #2;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, m_wait});
        check({tag, "_err"},  {31'd0, err},  {31'd0, m_err});
        check({tag, "_num1"}, {22'd0, num1}, {22'd0, m_a});
        check({tag, "_num2"}, {22'd0, num2}, {22'd0, m_b});
        check({tag, "_op"},   {28'd0, op},   {28'd0, m_op});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_num1"},  {22'd0, num1}, 32'd0);
        check({tag, "_num2"},  {22'd0, num2}, 32'd0);
        check({tag, "_op"},    {28'd0, op},   32'd0);
        check({tag, "_start"}, {31'd0, start}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_err"},   {31'd0, err},  32'd0);
    endtask

    // monitor: every start pulse must match the oldest predicted transaction
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b0 && start === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL start_unexpected: actual start=1 required no start");
            end else begin
                e = sb_q.pop_front();
                check("start_num1", {22'd0, num1}, {22'd0, e.a});
                check("start_num2", {22'd0, num2}, {22'd0, e.b});
                check("start_op",   {28'd0, op},   {28'd0, e.o});
                check("start_err",  {31'd0, err},  {31'd0, e.e});
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] val, old_a, p;
        logic             clr;
        model_reset();
        reset = 1'b1;
        in = 12'h000;
        calc_done = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clock);
        #2;

        // basic load
        send_word(10'h155, 1'b0, 1'b0);
        send_word(10'h0AA, 1'b0, 1'b0);
        send_word(10'h003, 1'b0, 1'b0);
        check_state("t1");
        pulse_done();
        check_state("t1_done");

        // capture latency and a long strobe counting once
        do val = WIDTH'($urandom); while (val == m_a);
        old_a = m_a;
        model_event(val, 1'b0);
        in = {2'b10, val};
        repeat (3) @(posedge clock);
        #1;
        check("lat_before", {22'd0, num1}, {22'd0, old_a});
        @(posedge clock);
        #1;
        check("lat_at", {22'd0, num1}, {22'd0, val});
        repeat (17) @(posedge clock);
        #1;
        in[11] = 1'b0;
        repeat (SS + 2) @(posedge clock);
        #2;
        send_word(WIDTH'($urandom), 1'b0, 1'b0);
        send_word(WIDTH'($urandom), 1'b0, 1'b0);
        check_state("t2");

        // write while waiting is dropped and flagged
        send_word(10'h3FF, 1'b0, 1'b0);
        check_state("t3_ignored");
        pulse_done();
        check_state("t3_done");
        send_word(10'h011, 1'b0, 1'b0);
        send_word(10'h022, 1'b0, 1'b0);
        send_word(10'h007, 1'b0, 1'b0);
        check_state("t3_reload");
        pulse_done();

        // clear word aborts partial load and drops err
        send_word(10'h001, 1'b0, 1'b0);
        send_word(10'h000, 1'b1, 1'b0);
        check_state("t4_clear");
        send_word(10'h010, 1'b0, 1'b0);
        send_word(10'h020, 1'b0, 1'b0);
        send_word(10'h005, 1'b0, 1'b0);
        check_state("t4");
        pulse_done();

        // reset in the middle of a load
        send_word(10'h2A1, 1'b0, 1'b0);
        send_word(10'h1B2, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_zero("t5_reset");
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #2;
        pulse_done();
        check_state("t5_idle_done");
        send_word(10'h0F0, 1'b0, 1'b0);
        send_word(10'h00F, 1'b0, 1'b0);
        send_word(10'h009, 1'b0, 1'b0);
        check_state("t5_reload");
        pulse_done();

        // calc_done during the firing cycle is too early
        send_word(10'h123, 1'b0, 1'b0);
        send_word(10'h321, 1'b0, 1'b0);
        send_word(10'h00C, 1'b0, 1'b1);
        check_state("t6_early");
        pulse_done();
        check_state("t6_done");

        // random traffic
        for (int i = 0; i < 40; i++) begin
            p   = WIDTH'($urandom);
            clr = ($urandom_range(0, 9) == 0);
            send_word(p, clr, 1'b0);
            if ($urandom_range(0, 2) == 0) pulse_done();
            check_state("rand");
        end

        repeat (5) @(posedge clock);
        #2;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
